// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter and the units that sit on it:
// bus width defaults, arbiter state/grant encodings and the burst-limit test.
package mem_bus_arbiter_pkg;

    localparam int unsigned AW_DEF = 20;   // word address width
    localparam int unsigned DW_DEF = 16;   // data width
    localparam int unsigned CW     = 4;    // burst counter width

    localparam logic [CW-1:0] CNT_MAX = CW'(15);

    // State encoding chosen so the grant vector is the state itself
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_OWN_I = 2'b01,
        ST_OWN_D = 2'b10
    } arb_state_e;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_I    = 2'b01;
    localparam logic [1:0] GNT_D    = 2'b10;

    // Grant vector for a given owner state
    function automatic logic [1:0] gnt_of(input arb_state_e s);
        logic [1:0] g;
        g = GNT_NONE;
        case (s)
            ST_OWN_I: g = GNT_I;
            ST_OWN_D: g = GNT_D;
            default:  g = GNT_NONE;
        endcase
        return g;
    endfunction

    // True when the word completing now would reach the burst limit
    function automatic logic limit_hit(input logic [CW-1:0] cnt, input int unsigned lim);
        logic [CW:0] nxt;
        nxt = {1'b0, cnt} + (CW+1)'(1);
        return nxt >= (CW+1)'(lim);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_burst_ctr.sv
// arb_burst_ctr: 4-bit saturating count of words completed by the current
// bus owner. Clear has priority over increment.
// Ports: clk, rst_n; clr (grant changes next cycle); inc (word boundary);
//        cnt (words completed since the grant was given).
module arb_burst_ctr
    import mem_bus_arbiter_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt
);

    // Saturating word counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one external memory bus between the prefetch unit
// (port I, read-only) and the load/store unit (port D, read/write). Grants
// change only at word boundaries or when the owner drops its request; bursts
// are bounded only while the other port waits.
// Ports: clk, rst_n; i_req/i_adr -> i_ack/i_dtr (prefetch);
//        d_req/d_we/d_adr/d_wdat -> d_ack/d_dtr (data unit);
//        m_req/m_we/m_adr/m_wdat <- m_ack/m_dtr (memory); gnt (current owner).
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned AW     = AW_DEF,
    parameter int unsigned DW     = DW_DEF,
    parameter int unsigned IBURST = 4,
    parameter int unsigned DBURST = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_req,
    input  logic [AW-1:0] i_adr,
    output logic          i_ack,
    output logic [DW-1:0] i_dtr,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_adr,
    input  logic [DW-1:0] d_wdat,
    output logic          d_ack,
    output logic [DW-1:0] d_dtr,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_adr,
    output logic [DW-1:0] m_wdat,
    input  logic          m_ack,
    input  logic [DW-1:0] m_dtr,
    output logic [1:0]    gnt
);

    arb_state_e    state;
    arb_state_e    state_nxt;
    logic [CW-1:0] cnt;
    logic          boundary_c;
    logic          cnt_clr_c;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and downstream mux. An owner dropping its request takes
    // precedence over any boundary handover in the same cycle.
    always_comb begin
        state_nxt = state;
        m_req     = 1'b0;
        m_we      = 1'b0;
        m_adr     = '0;
        m_wdat    = '0;
        unique case (state)
            ST_IDLE: begin
                if (d_req) begin
                    state_nxt = ST_OWN_D;
                end else if (i_req) begin
                    state_nxt = ST_OWN_I;
                end
            end
            ST_OWN_I: begin
                m_req = i_req;
                m_adr = i_adr;
                if (!i_req) begin
                    state_nxt = d_req ? ST_OWN_D : ST_IDLE;
                end else if (m_ack && d_req && limit_hit(cnt, IBURST)) begin
                    state_nxt = ST_OWN_D;
                end
            end
            ST_OWN_D: begin
                m_req  = d_req;
                m_we   = d_we;
                m_adr  = d_adr;
                m_wdat = d_wdat;
                if (!d_req) begin
                    state_nxt = i_req ? ST_OWN_I : ST_IDLE;
                end else if (m_ack && i_req && limit_hit(cnt, DBURST)) begin
                    state_nxt = ST_OWN_I;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // m_ack is meaningless without an owner
    assign boundary_c = m_ack && (state != ST_IDLE);
    assign cnt_clr_c  = (state_nxt != state);

    arb_burst_ctr u_burst_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr_c),
        .inc   (boundary_c),
        .cnt   (cnt)
    );

    assign i_ack = m_ack && (state == ST_OWN_I);
    assign d_ack = m_ack && (state == ST_OWN_D);
    assign i_dtr = m_dtr;
    assign d_dtr = m_dtr;
    assign gnt   = gnt_of(state);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: a simple always-ready memory model plus
// requester drivers; expected ack order/data is queued per scenario and
// checked as acks appear.
module tb_mem_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic        i_req;
    logic [19:0] i_adr;
    logic        i_ack;
    logic [15:0] i_dtr;
    logic        d_req;
    logic        d_we;
    logic [19:0] d_adr;
    logic [15:0] d_wdat;
    logic        d_ack;
    logic [15:0] d_dtr;
    logic        m_req;
    logic        m_we;
    logic [19:0] m_adr;
    logic [15:0] m_wdat;
    logic        m_ack;
    logic [15:0] m_dtr;
    logic [1:0]  gnt;

    logic        ack_en;

    typedef struct {
        logic [1:0]  port;
        logic [15:0] rdat;
        logic        we;
        logic [15:0] wdat;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_errors = 0;

    int i_left, d_left, i_done, d_done, i_after, d_after, gnt_chg;
    logic [1:0] prev_gnt;

    mem_bus_arbiter #(.AW(20), .DW(16), .IBURST(4), .DBURST(2)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_req  (i_req),
        .i_adr  (i_adr),
        .i_ack  (i_ack),
        .i_dtr  (i_dtr),
        .d_req  (d_req),
        .d_we   (d_we),
        .d_adr  (d_adr),
        .d_wdat (d_wdat),
        .d_ack  (d_ack),
        .d_dtr  (d_dtr),
        .m_req  (m_req),
        .m_we   (m_we),
        .m_adr  (m_adr),
        .m_wdat (m_wdat),
        .m_ack  (m_ack),
        .m_dtr  (m_dtr),
        .gnt    (gnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory returns an address-derived pattern and completes a word per cycle
    function automatic logic [15:0] mem_f(input logic [19:0] a);
        return a[15:0] ^ 16'hA5A5 ^ {12'h000, a[19:16]};
    endfunction

    assign m_ack = ack_en & m_req;
    assign m_dtr = mem_f(m_adr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic push_i(input logic [19:0] a);
        exp_q.push_back('{port: 2'd1, rdat: mem_f(a), we: 1'b0, wdat: 16'h0});
    endtask

    task automatic push_d(input logic [19:0] a, input logic we, input logic [15:0] wd);
        exp_q.push_back('{port: 2'd2, rdat: mem_f(a), we: we, wdat: wd});
    endtask

    // Scoreboard: every ack must match the next queued word
    always @(negedge clk) begin
        if (rst_n && (i_ack || d_ack)) begin
            if (i_ack && d_ack) begin
                chk("both_ack", 32'd1, 32'd0);
            end else if (exp_q.size() == 0) begin
                chk("extra_ack", {30'd0, d_ack, i_ack}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("ack_port", {30'd0, d_ack, i_ack}, {30'd0, mon_e.port});
                chk("ack_rdat", {16'd0, (i_ack ? i_dtr : d_dtr)}, {16'd0, mon_e.rdat});
                chk("ack_we", {31'd0, m_we}, {31'd0, mon_e.we});
                if (mon_e.we) chk("ack_wdat", {16'd0, m_wdat}, {16'd0, mon_e.wdat});
            end
        end
    end

    task automatic apply_reqs();
        i_req = (i_left > 0) && (d_done >= i_after);
        d_req = (d_left > 0) && (i_done >= d_after);
    endtask

    // One bus cycle: sample at negedge, advance requesters just after posedge
    task automatic cycle();
        logic ia, da;
        @(negedge clk);
        ia = i_ack;
        da = d_ack;
        if (gnt != prev_gnt) gnt_chg++;
        prev_gnt = gnt;
        @(posedge clk);
        #1;
        if (ia) begin i_adr = i_adr + 20'd1; i_done++; i_left--; end
        if (da) begin d_adr = d_adr + 20'd1; d_wdat = d_wdat + 16'd1; d_done++; d_left--; end
        apply_reqs();
    endtask

    task automatic scen(input string tag, input int il, input int dl, input int ia, input int da,
                        input logic [19:0] ib, input logic [19:0] db, input logic dwe,
                        input logic [15:0] dwd, input int exp_cyc, input int exp_chg);
        int n;
        i_left = il; d_left = dl; i_after = ia; d_after = da;
        i_done = 0; d_done = 0; gnt_chg = 0; prev_gnt = gnt;
        i_adr = ib; d_adr = db; d_we = dwe; d_wdat = dwd;
        ack_en = 1'b1;
        apply_reqs();
        n = 0;
        while ((i_left > 0 || d_left > 0) && n < 60) begin
            cycle();
            n++;
        end
        chk({tag, "_cycles"}, n, exp_cyc);
        chk({tag, "_gnt_changes"}, gnt_chg, exp_chg);
        cycle();
        cycle();
        chk({tag, "_idle_gnt"}, {30'd0, gnt}, 32'd0);
        chk({tag, "_queue_empty"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; ack_en = 1'b0;
        i_req = 1'b1; i_adr = 20'h12345;
        d_req = 1'b0; d_we = 1'b0; d_adr = '0; d_wdat = '0;
        i_left = 0; d_left = 0; i_done = 0; d_done = 0; i_after = 0; d_after = 0;
        gnt_chg = 0; prev_gnt = 2'b00;

        // Reset held with a pending prefetch request
        repeat (3) @(negedge clk);
        chk("rst_gnt", {30'd0, gnt}, 32'd0);
        chk("rst_mreq", {31'd0, m_req}, 32'd0);
        chk("rst_madr", {12'd0, m_adr}, 32'd0);
        chk("rst_iack", {31'd0, i_ack}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_gnt", {30'd0, gnt}, 32'd1);
        chk("rel_mreq", {31'd0, m_req}, 32'd1);
        chk("rel_madr", {12'd0, m_adr}, 32'h12345);
        chk("rel_mwe", {31'd0, m_we}, 32'd0);

        // Flush: owner drops mid-word with nothing else requesting
        i_req = 1'b0;
        @(negedge clk);
        chk("flush_mreq", {31'd0, m_req}, 32'd0);
        chk("flush_iack", {31'd0, i_ack}, 32'd0);
        @(posedge clk); #1;
        chk("flush_gnt", {30'd0, gnt}, 32'd0);
        i_req = 1'b1; i_adr = 20'h0A2C1;
        @(posedge clk); #1;
        chk("regrant_gnt", {30'd0, gnt}, 32'd1);
        chk("regrant_madr", {12'd0, m_adr}, 32'h0A2C1);
        i_req = 1'b0;
        @(posedge clk); #1;
        chk("regrant_drop_gnt", {30'd0, gnt}, 32'd0);

        // Priority: both request from idle, D wins
        i_req = 1'b1; d_req = 1'b1; d_adr = 20'h00100; d_we = 1'b1; d_wdat = 16'hBEEF;
        @(posedge clk); #1;
        chk("pri_gnt", {30'd0, gnt}, 32'd2);
        chk("pri_mwe", {31'd0, m_we}, 32'd1);
        chk("pri_wdat", {16'd0, m_wdat}, 32'h0000BEEF);
        chk("pri_madr", {12'd0, m_adr}, 32'h00100);
        push_d(20'h00100, 1'b1, 16'hBEEF);
        ack_en = 1'b1;
        @(negedge clk);
        chk("pri_iack", {31'd0, i_ack}, 32'd0);
        chk("pri_dack", {31'd0, d_ack}, 32'd1);
        @(posedge clk); #1;
        ack_en = 1'b0; i_req = 1'b0; d_req = 1'b0;
        @(posedge clk); #1;
        chk("pri_end_gnt", {30'd0, gnt}, 32'd0);
        chk("pri_queue_empty", exp_q.size(), 32'd0);

        // I burst: D arrives after word 1, I gets 4 words, D 2, then I resumes
        for (int k = 0; k < 4; k++) push_i(20'h01000 + 20'(k));
        push_d(20'h00300, 1'b1, 16'h1200);
        push_d(20'h00301, 1'b1, 16'h1201);
        push_i(20'h01004);
        push_i(20'h01005);
        scen("iburst", 6, 2, 0, 1, 20'h01000, 20'h00300, 1'b1, 16'h1200, 9, 3);

        // D burst: D limited to 2 while I waits; I drop hands back to D
        push_d(20'h00200, 1'b0, 16'h0);
        push_d(20'h00201, 1'b0, 16'h0);
        push_i(20'h02000);
        push_i(20'h02001);
        push_d(20'h00202, 1'b0, 16'h0);
        scen("dburst", 2, 3, 0, 0, 20'h02000, 20'h00200, 1'b0, 16'h0, 7, 3);

        // Sole requester keeps the bus indefinitely
        for (int k = 0; k < 20; k++) push_i(20'h0A000 + 20'(k));
        scen("sole", 20, 0, 0, 0, 20'h0A000, 20'h00000, 1'b0, 16'h0, 21, 1);

        // Reset asserted mid-word abandons it at once
        ack_en = 1'b0; i_req = 1'b1; i_adr = 20'h00055;
        @(posedge clk); #1;
        chk("midrst_own", {30'd0, gnt}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_gnt", {30'd0, gnt}, 32'd0);
        chk("midrst_mreq", {31'd0, m_req}, 32'd0);
        chk("midrst_madr", {12'd0, m_adr}, 32'd0);
        @(negedge clk);
        i_req = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single 16-bit external memory bus (20-bit word address) between two requesters: the instruction prefetch unit (port I, read-only) and the load/store data unit (port D, read/write).
- Sits between the CPU core and the memory interface.
- Sequences grants at word boundaries with bounded bursts, so neither requester starves.
- Data port has priority when both request from idle.

Parameters:
- AW, 20, word address width.
- DW, 16, data width.
- IBURST, 4, max consecutive words granted to port I while D is waiting (1..15).
- DBURST, 2, max consecutive words granted to port D while I is waiting (1..15).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_req  in  1  prefetch request; held high while words are wanted.
- i_adr  in  AW  prefetch word address, valid with i_req.
- i_ack  out  1  one pulse per completed prefetch word.
- i_dtr  out  DW  read data to prefetch, valid when i_ack=1.
- d_req  in  1  data unit request.
- d_we  in  1  1 = write, 0 = read; valid with d_req.
- d_adr  in  AW  data word address.
- d_wdat  in  DW  write data.
- d_ack  out  1  one pulse per completed data word.
- d_dtr  out  DW  read data to data unit, valid when d_ack=1.
- m_req  out  1  memory bus request.
- m_we  out  1  memory write enable.
- m_adr  out  AW  memory address.
- m_wdat  out  DW  memory write data.
- m_ack  in  1  memory completes one word in the cycle it is high.
- m_dtr  in  DW  memory read data, valid with m_ack.
- gnt  out  2  current owner: 00 none, 01 I, 10 D (debug/visibility).

Behaviour:
- Reset (async, rst_n=0): state IDLE, gnt=00, burst counter 0. m_req, m_we, i_ack and d_ack are 0. m_adr and m_wdat are 0. Reset mid-transfer abandons the word; nothing is acked.
- States: IDLE, OWN_I, OWN_D (registered). gnt mirrors the state.
- Downstream signals are combinational from the state:
  - OWN_I: m_req=i_req, m_adr=i_adr, m_we=0.
  - OWN_D: m_req=d_req, m_adr=d_adr, m_we=d_we, m_wdat=d_wdat.
  - IDLE: all downstream outputs 0.
- i_ack = m_ack & OWN_I. d_ack = m_ack & OWN_D. m_ack in IDLE is ignored.
- i_dtr = d_dtr = m_dtr unconditionally. Consumers qualify with their ack.
- IDLE:
  - d_req → OWN_D.
  - else i_req → OWN_I.
  - Grant latency is 1 cycle: m_req rises the cycle after the request is seen.
- Owner port X, other port Y:
  - Word boundary = cycle with m_ack=1. The counter increments at each boundary and clears on grant change.
  - X drops req (any cycle, including mid-word with no ack, i.e. flush): go to OWN_Y if Y requests, else IDLE. The pending word is abandoned and the memory interface must tolerate m_req deassertion.
  - At a boundary, if Y is requesting and count+1 ≥ X's burst limit: switch directly to OWN_Y next cycle. There is no idle gap and the counter resets.
  - Otherwise stay; X keeps the bus while holding req, even when Y is idle (no limit).
- Ownership never changes except at a boundary, on the owner dropping req, or on reset. No word is split across owners.
- Simultaneous owner drop and boundary: the drop rule wins, so the grant goes to Y or IDLE.
- Both requesters present at IDLE: D wins.
- Counter is 4 bits and saturates at 15.

Decomposition:
- Shared package/header: state encodings (ST_IDLE, ST_OWN_I, ST_OWN_D), gnt encodings, AW/DW defaults shared with the prefetch unit.
- One natural sub-module: arb_burst_ctr (4-bit saturating counter with clear and increment-at-boundary). The mux and FSM stay in the top.

Test Plan:
- Reset: hold rst_n=0 with i_req=1, then release → gnt=00 and m_req=0 during reset; gnt=01 on the 1st edge after release; m_adr=i_adr from that cycle.
- Priority: i_req=d_req=1 from IDLE, d_adr=20'h00100, d_we=1, d_wdat=16'hBEEF → gnt=10, m_we=1, m_wdat=16'hBEEF; i_ack stays 0.
- I burst fairness: I owns with m_ack=1 every cycle, d_req raised at word 1, IBURST=4 → exactly 4 i_ack pulses, then gnt=10 in the next cycle; the first d_ack follows.
- D burst fairness: D owns with continuous m_ack, i_req=1, DBURST=2 → 2 d_ack pulses, then gnt=01.
- Flush/abandon: I owns, m_ack=0, i_req drops with d_req=0 → gnt=00 next cycle, no i_ack; i_req reasserted with i_adr=20'h0A2C1 → m_adr=20'h0A2C1 one cycle later.
- Sole requester: only i_req high for 20 words of continuous m_ack → gnt stays 01 throughout, 20 i_ack pulses, no grant change.
